// File: rtl/aes_block_packer.sv
// aes_block_packer: gathers a byte stream into 128-bit AES state blocks and
// queues finished blocks in a small FIFO behind a valid/ready interface, so the
// cipher core always sees a stable block on m_data.
module aes_block_packer #(
  parameter int DEPTH     = 2,     // finished-block FIFO entries: 1, 2 or 4
  parameter bit MSB_FIRST = 1'b1   // 1: first byte lands in [127:120]
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_first,
  output logic         s_ready,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [3:0]   byte_cnt,
  output logic         discard
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t         r_state;
  logic [3:0]     r_byte_cnt;
  logic [127:0]   r_asm;
  logic           r_discard;
  logic [127:0]   r_fifo [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [127:0]   w_asm_next;

  // Pointer advance that wraps modulo DEPTH (also correct for non power-of-two).
  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // s_ready only looks at registered state, so a pop in the same cycle
  // cannot open the gate for a byte that would complete a block.
  assign s_ready  = (r_byte_cnt != 4'd15) | (r_count != FULL_CNT);
  assign w_accept = s_valid & s_ready;
  assign w_pop    = (r_count != '0) & m_ready;
  assign w_push   = w_accept & ~s_first & (r_byte_cnt == 4'd15);

  // New byte shifts in from the side that ends up holding the last byte.
  assign w_asm_next = MSB_FIRST ? {r_asm[119:0], s_data} : {s_data, r_asm[127:8]};

  // Block assembly FSM: IDLE between blocks, FILL while a partial block is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= 4'd0;
      r_asm      <= '0;
      r_discard  <= 1'b0;
    end else begin
      r_discard <= 1'b0;
      if (w_accept) begin
        r_asm <= w_asm_next;
        if (s_first) begin
          r_discard  <= (r_state == ST_FILL);
          r_byte_cnt <= 4'd1;
          r_state    <= ST_FILL;
        end else if (r_byte_cnt == 4'd15) begin
          r_byte_cnt <= 4'd0;
          r_state    <= ST_IDLE;
        end else begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
          r_state    <= ST_FILL;
        end
      end
    end
  end

  // Finished-block FIFO; push and pop in one cycle leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_asm_next;
        r_wr_ptr         <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_valid  = (r_count != '0);
  assign m_data   = r_fifo[r_rd_ptr];
  assign byte_cnt = r_byte_cnt;
  assign discard  = r_discard;

endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: directed and randomized checks of aes_block_packer in
// four configurations, against a byte-queue / block-queue reference model.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   sData   [4];
  logic         sValid  [4];
  logic         sFirst  [4];
  logic         mReady  [4];
  logic         sReady  [4];
  logic         mValid  [4];
  logic         discard [4];
  logic [127:0] mData   [4];
  logic [3:0]   byteCnt [4];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bytes of the open block, and blocks waiting in the FIFO.
  int           cur = 0;
  int           curDepth = 2;
  bit           curMsb = 1'b1;
  logic [7:0]   part [$];
  logic [127:0] expQ [$];
  logic         expDiscard = 1'b0;
  int           blocksOut = 0;

  // Free-running 100 MHz clock shared by all instances.
  always #5 clk = ~clk;

  aes_block_packer #(.DEPTH(2), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(sData[0]), .s_valid(sValid[0]), .s_first(sFirst[0]),
    .s_ready(sReady[0]), .m_data(mData[0]), .m_valid(mValid[0]), .m_ready(mReady[0]),
    .byte_cnt(byteCnt[0]), .discard(discard[0]));

  aes_block_packer #(.DEPTH(1), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(sData[1]), .s_valid(sValid[1]), .s_first(sFirst[1]),
    .s_ready(sReady[1]), .m_data(mData[1]), .m_valid(mValid[1]), .m_ready(mReady[1]),
    .byte_cnt(byteCnt[1]), .discard(discard[1]));

  aes_block_packer #(.DEPTH(4), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(sData[2]), .s_valid(sValid[2]), .s_first(sFirst[2]),
    .s_ready(sReady[2]), .m_data(mData[2]), .m_valid(mValid[2]), .m_ready(mReady[2]),
    .byte_cnt(byteCnt[2]), .discard(discard[2]));

  aes_block_packer #(.DEPTH(2), .MSB_FIRST(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .s_data(sData[3]), .s_valid(sValid[3]), .s_first(sFirst[3]),
    .s_ready(sReady[3]), .m_data(mData[3]), .m_valid(mValid[3]), .m_ready(mReady[3]),
    .byte_cnt(byteCnt[3]), .discard(discard[3]));

  // Byte i of a block sits at [127-8i -: 8] when MSB first, else at [8i +: 8].
  function automatic logic [127:0] pack_bytes(input bit msb);
    logic [127:0] blk;
    blk = '0;
    for (int i = 0; i < 16; i++) begin
      if (msb) blk[127-8*i -: 8] = part[i];
      else     blk[8*i +: 8]     = part[i];
    end
    return blk;
  endfunction

  function automatic bit exp_s_ready();
    return !((part.size() == 15) && (expQ.size() == curDepth));
  endfunction

  task automatic clear_model();
    part.delete();
    expQ.delete();
    expDiscard = 1'b0;
    blocksOut = 0;
  endtask

  task automatic select_dut(input int idx);
    cur = idx;
    curDepth = (idx == 1) ? 1 : (idx == 2) ? 4 : 2;
    curMsb = (idx != 3);
    clear_model();
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 4; i++) begin
      sValid[i] = 1'b0; sData[i] = 8'h00; sFirst[i] = 1'b0; mReady[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
  endtask

  // Drive one cycle of stimulus on the selected instance and advance the model.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic f, input logic mr);
    bit acc;
    bit xfer;
    sValid[cur] = v; sData[cur] = d; sFirst[cur] = f; mReady[cur] = mr;
    acc  = v && exp_s_ready();
    xfer = mr && (expQ.size() != 0);
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(expQ.pop_front());
      blocksOut++;
    end
    expDiscard = 1'b0;
    if (acc) begin
      if (f) begin
        expDiscard = (part.size() != 0);
        part.delete();
        part.push_back(d);
      end else begin
        part.push_back(d);
        if (part.size() == 16) begin
          expQ.push_back(pack_bytes(curMsb));
          part.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (byteCnt[i] !== 4'd0 || mValid[i] !== 1'b0 || mData[i] !== 128'd0 ||
          discard[i] !== 1'b0 || sReady[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_state inst%0d: got cnt=%0d mv=%b md=%h disc=%b rdy=%b expected 0/0/0/0/1",
                 i, byteCnt[i], mValid[i], mData[i], discard[i], sReady[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    select_dut(0);
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0, 1'b1);
      if (i == 4) begin
        vectors++;
        if (byteCnt[cur] !== 4'd5) begin
          miscompares++;
          $display("[TB] FAIL b2b_cnt5: got %0d expected 5", byteCnt[cur]);
        end
      end
    end
    vectors++;
    if (mValid[cur] !== 1'b1 || mData[cur] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      miscompares++;
      $display("[TB] FAIL b2b_block: got mv=%b md=%h expected 1 000102030405060708090a0b0c0d0e0f",
               mValid[cur], mData[cur]);
    end
    vectors++;
    if (byteCnt[cur] !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL b2b_cnt_wrap: got %0d expected 0", byteCnt[cur]);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (mValid[cur] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_one_cycle: got mv=%b expected 0", mValid[cur]);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    select_dut(0);
    for (int i = 0; i < 47; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    vectors++;
    if (sReady[cur] !== 1'b0 || byteCnt[cur] !== 4'd15 || mValid[cur] !== 1'b1 ||
        mData[cur] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      miscompares++;
      $display("[TB] FAIL bp_full: got rdy=%b cnt=%0d mv=%b md=%h expected 0 15 1 block1",
               sReady[cur], byteCnt[cur], mValid[cur], mData[cur]);
    end
    // Byte 48 is offered but refused; block 1 leaves.
    drive_cycle(1'b1, 8'd47, 1'b0, 1'b1);
    vectors++;
    if (mData[cur] !== 128'h101112131415161718191a1b1c1d1e1f || byteCnt[cur] !== 4'd15 ||
        sReady[cur] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_block2: got md=%h cnt=%0d rdy=%b expected block2 15 1",
               mData[cur], byteCnt[cur], sReady[cur]);
    end
    // Byte 48 accepted while block 2 leaves: push and pop at count 1.
    drive_cycle(1'b1, 8'd47, 1'b0, 1'b1);
    vectors++;
    if (mValid[cur] !== 1'b1 || mData[cur] !== 128'h202122232425262728292a2b2c2d2e2f) begin
      miscompares++;
      $display("[TB] FAIL bp_block3: got mv=%b md=%h expected 1 block3", mValid[cur], mData[cur]);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (mValid[cur] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_drain: got mv=%b expected 0", mValid[cur]);
    end
  endtask

  task automatic test_resync();
    reset_dut();
    select_dut(0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h80, 1'b1, 1'b0);
    vectors++;
    if (discard[cur] !== 1'b1 || byteCnt[cur] !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL resync_pulse: got disc=%b cnt=%0d expected 1 1", discard[cur], byteCnt[cur]);
    end
    for (int i = 1; i < 16; i++) begin
      drive_cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      if (i == 1) begin
        vectors++;
        if (discard[cur] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL resync_pulse_len: got disc=%b expected 0", discard[cur]);
        end
      end
    end
    vectors++;
    if (mValid[cur] !== 1'b1 || mData[cur] !== 128'h808182838485868788898a8b8c8d8e8f) begin
      miscompares++;
      $display("[TB] FAIL resync_block: got mv=%b md=%h expected 1 808182838485868788898a8b8c8d8e8f",
               mValid[cur], mData[cur]);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (mValid[cur] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL resync_no_stale: got mv=%b expected 0", mValid[cur]);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    select_dut(0);
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)  drive_cycle(1'b1, 8'h22, 1'b0, 1'b0);
    vectors++;
    if (byteCnt[cur] !== 4'd9 || mValid[cur] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: got cnt=%0d mv=%b expected 9 1", byteCnt[cur], mValid[cur]);
    end
    sValid[cur] = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mValid[cur] !== 1'b0 || byteCnt[cur] !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: got mv=%b cnt=%0d expected 0 0", mValid[cur], byteCnt[cur]);
    end
    clear_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'haa, 1'b0, 1'b0);
    vectors++;
    if (mValid[cur] !== 1'b1 || mData[cur] !== {16{8'haa}} || byteCnt[cur] !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_aa: got mv=%b md=%h cnt=%0d expected 1 all-aa 0",
               mValid[cur], mData[cur], byteCnt[cur]);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (mValid[cur] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_single: got mv=%b expected 0", mValid[cur]);
    end
  endtask

  task automatic test_lsb_first();
    reset_dut();
    select_dut(3);
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    vectors++;
    if (mValid[cur] !== 1'b1 || mData[cur] !== 128'h0f0e0d0c0b0a09080706050403020100) begin
      miscompares++;
      $display("[TB] FAIL lsb_block: got mv=%b md=%h expected 1 0f0e0d0c0b0a09080706050403020100",
               mValid[cur], mData[cur]);
    end
  endtask

  task automatic test_random(input int idx, input int nBlocks);
    int cycles;
    logic v, f, mr;
    logic [7:0] d;
    reset_dut();
    select_dut(idx);
    cycles = 0;
    while (blocksOut < nBlocks && cycles < 20000) begin
      vectors++;
      if (byteCnt[cur] !== 4'(part.size()) || mValid[cur] !== (expQ.size() != 0) ||
          sReady[cur] !== exp_s_ready() || discard[cur] !== expDiscard ||
          (expQ.size() != 0 && mData[cur] !== expQ[0])) begin
        miscompares++;
        $display("[TB] FAIL random_inst%0d cyc%0d: got cnt=%0d mv=%b rdy=%b disc=%b md=%h expected cnt=%0d mv=%b rdy=%b disc=%b md=%h",
                 idx, cycles, byteCnt[cur], mValid[cur], sReady[cur], discard[cur], mData[cur],
                 part.size(), expQ.size() != 0, exp_s_ready(), expDiscard,
                 (expQ.size() != 0) ? expQ[0] : 128'd0);
      end
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 39) == 0);
      mr = (((cycles / 64) % 3) == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      d  = 8'($urandom);
      drive_cycle(v, d, f, mr);
      cycles++;
    end
    vectors++;
    if (blocksOut < nBlocks) begin
      miscompares++;
      $display("[TB] FAIL random_timeout inst%0d: got %0d blocks expected %0d", idx, blocksOut, nBlocks);
    end
    sValid[cur] = 1'b0;
    mReady[cur] = 1'b0;
  endtask

  // Test sequence: directed scenarios first, then randomized runs per configuration.
  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_lsb_first();
    for (int i = 0; i < 4; i++) test_random(i, 50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
